// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared 16-bit ALU: accepts one request, drives the ALU, serialises writebacks.
// Optional divide-by-zero abort enabled by defining ALU_ISSUE_DIVZERO_CHK_EN.
module alu_issue_ctrl #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int R15_ADDR = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [REG_AW-1:0] req_rd1,
  input  logic [REG_AW-1:0] req_rd2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_select,
  input  logic [DATA_W-1:0] alu_op1data,
  input  logic [DATA_W-1:0] alu_op2data,
  input  logic [DATA_W-1:0] alu_r15,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, EXEC, WB1, WB2} state_t;

  localparam logic [2:0]        OP_MUL  = 3'd2;
  localparam logic [2:0]        OP_DIV  = 3'd3;
  localparam logic [2:0]        OP_SWAP = 3'd5;
  localparam logic [REG_AW-1:0] R15     = REG_AW'(R15_ADDR);

`ifdef ALU_ISSUE_DIVZERO_CHK_EN
  localparam bit DIVZ_CHK = 1'b1;
`else
  localparam bit DIVZ_CHK = 1'b0;
`endif

  state_t              state;
  logic [2:0]          op_p0;
  logic [REG_AW-1:0]   rd1_p0;
  logic [REG_AW-1:0]   rd2_p0;
  logic                divz_p0;
  logic [DATA_W-1:0]   op2_p1;
  logic [DATA_W-1:0]   r15_p1;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  function automatic logic two_writes(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_SWAP);
  endfunction

  // Outputs are registered: each state's writeback values are loaded on the edge that enters it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      divz_p0    <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        // stage p0: accept and latch the request
        IDLE: begin
          if (req_valid) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_select <= req_op;
            op_p0      <= req_op;
            rd1_p0     <= req_rd1;
            rd2_p0     <= req_rd2;
            if (DIVZ_CHK && (req_op == OP_DIV) && (req_b == '0)) begin
              divz_p0 <= 1'b1;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              divz_p0 <= 1'b0;
            end
            state <= EXEC;
          end
        end
        // stage p1: capture ALU results, first writeback goes out next cycle
        EXEC: begin
          if (divz_p0) begin
            state <= IDLE;
          end else begin
            op2_p1  <= alu_op2data;
            r15_p1  <= alu_r15;
            wb_en   <= 1'b1;
            wb_addr <= rd1_p0;
            wb_data <= alu_op1data;
            done    <= !two_writes(op_p0);
            state   <= WB1;
          end
        end
        // stage p2: optional second writeback
        WB1: begin
          if (two_writes(op_p0)) begin
            wb_en <= 1'b1;
            done  <= 1'b1;
            if (op_p0 == OP_SWAP) begin
              wb_addr <= rd2_p0;
              wb_data <= op2_p1;
            end else begin
              wb_addr <= R15;
              wb_data <= r15_p1;
            end
            state <= WB2;
          end else begin
            state <= IDLE;
          end
        end
        WB2: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized ops against a reference model.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_rd1;
  logic [3:0]  req_rd2;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_select;
  logic [15:0] alu_op1data;
  logic [15:0] alu_op2data;
  logic [15:0] alu_r15;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        done;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(.DATA_W(16), .REG_AW(4), .R15_ADDR(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd1(req_rd1), .req_rd2(req_rd2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_op1data(alu_op1data), .alu_op2data(alu_op2data), .alu_r15(alu_r15),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU; op2 and r15 carry distinctive junk when the op does not define them.
  function automatic logic [47:0] alu_stub(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, p;
    logic [15:0] o1, o2, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    o1 = 16'h0;
    o2 = a ^ 16'h5a5a;
    r  = b ^ 16'ha5a5;
    case (s)
      3'd0: o1 = 16'(sa + sb);
      3'd1: o1 = 16'(sa - sb);
      3'd2: begin p = sa * sb; o1 = p[15:0]; r = p[31:16]; end
      3'd3: if (b == 16'h0) begin o1 = 16'hffff; r = a; end
            else begin o1 = 16'(sa / sb); r = 16'(sa % sb); end
      3'd4: o1 = a;
      3'd5: begin o1 = b; o2 = a; end
      3'd6: o1 = a & b;
      default: o1 = a | b;
    endcase
    return {r, o2, o1};
  endfunction

  assign {alu_r15, alu_op2data, alu_op1data} = alu_stub(alu_select, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected register writes derived from the operation's meaning.
  task automatic ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd1, input logic [3:0] rd2,
                        output int n, output logic [3:0] a0, output logic [3:0] a1,
                        output logic [15:0] d0, output logic [15:0] d1, output logic er);
    int sa, sb, p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n = 1; a0 = rd1; a1 = 4'd0; d0 = 16'h0; d1 = 16'h0; er = 1'b0;
    case (op)
      3'd0: d0 = 16'(sa + sb);
      3'd1: d0 = 16'(sa - sb);
      3'd2: begin p = sa * sb; n = 2; a1 = 4'd15; d0 = 16'(p); d1 = 16'(p >>> 16); end
      3'd3: begin
        if (b == 16'h0) begin
`ifdef ALU_ISSUE_DIVZERO_CHK_EN
          n = 0; er = 1'b1;
`else
          n = 2; a1 = 4'd15; d0 = 16'hffff; d1 = a;
`endif
        end else begin
          n = 2; a1 = 4'd15; d0 = 16'(sa / sb); d1 = 16'(sa % sb);
        end
      end
      3'd4: d0 = a;
      3'd5: begin n = 2; d0 = b; a1 = rd2; d1 = a; end
      3'd6: d0 = a & b;
      default: d0 = a | b;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd1, input logic [3:0] rd2,
                        input int en, input logic [3:0] ea0, input logic [3:0] ea1,
                        input logic [15:0] ed0, input logic [15:0] ed1, input logic eerr);
    int t, nwr, ndone, nerr, done_at;
    logic [3:0]  wa [2];
    logic [15:0] wd [2];
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd1 = rd1; req_rd2 = rd2;
    @(negedge clk);
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom);
    check({tag, "_sel"},   32'(alu_select), 32'(op));
    check({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    check({tag, "_alu_b"}, 32'(alu_b), 32'(b));
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_nrdy"},  32'(req_ready), 32'd0);
    nwr = 0; ndone = 0; nerr = 0; done_at = -1;
    wa[0] = 4'd0; wa[1] = 4'd0; wd[0] = 16'h0; wd[1] = 16'h0;
    for (int c = 0; c < 6 && ndone == 0; c++) begin
      if (c > 0) @(negedge clk);
      if (wb_en) begin
        if (nwr < 2) begin wa[nwr] = wb_addr; wd[nwr] = wb_data; end
        nwr++;
      end
      if (err) nerr++;
      if (done) begin ndone++; done_at = c; end
    end
    check({tag, "_nwr"},    32'(nwr), 32'(en));
    check({tag, "_done"},   32'(ndone), 32'd1);
    check({tag, "_donecy"}, 32'(done_at), eerr ? 32'd0 : 32'(en));
    check({tag, "_err"},    32'(nerr), 32'(eerr));
    if (en >= 1) begin
      check({tag, "_wa0"}, 32'(wa[0]), 32'(ea0));
      check({tag, "_wd0"}, 32'(wd[0]), 32'(ed0));
    end
    if (en >= 2) begin
      check({tag, "_wa1"}, 32'(wa[1]), 32'(ea1));
      check({tag, "_wd1"}, 32'(wd[1]), 32'(ed1));
    end
    @(negedge clk);
    check({tag, "_rdy_after"}, 32'(req_ready), 32'd1);
    check({tag, "_idle_wb"},   32'(wb_en), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_hold_a"},    32'(alu_a), 32'(a));
  endtask

  initial begin
    int n;
    logic [3:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        er;
    logic [2:0]  rop;
    logic [15:0] ra, rb;
    logic [3:0]  r1, r2;
    int wcnt;

    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 16'h0; req_b = 16'h0;
    req_rd1 = 4'd0; req_rd2 = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_sel",   32'(alu_select), 32'd0);
    check("rst_waddr", 32'(wb_addr), 32'd0);
    check("rst_wdata", 32'(wb_data), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // add accepted while an or request waits behind it
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'd15; req_b = 16'd10; req_rd1 = 4'd3;
    @(negedge clk);
    req_op = 3'd7; req_a = 16'd4; req_b = 16'd3; req_rd1 = 4'd7;
    check("b2b_exec_sel", 32'(alu_select), 32'd0);
    check("b2b_exec_a",   32'(alu_a), 32'd15);
    check("b2b_exec_wb",  32'(wb_en), 32'd0);
    @(negedge clk);
    check("add_wb_en",   32'(wb_en), 32'd1);
    check("add_wb_addr", 32'(wb_addr), 32'd3);
    check("add_wb_data", 32'(wb_data), 32'd25);
    check("add_done",    32'(done), 32'd1);
    check("add_nrdy",    32'(req_ready), 32'd0);
    check("b2b_hold_sel", 32'(alu_select), 32'd0);
    @(negedge clk);
    check("add_rdy_k3", 32'(req_ready), 32'd1);
    check("add_wb_off", 32'(wb_en), 32'd0);
    check("add_hold_wd", 32'(wb_data), 32'd25);
    @(negedge clk);
    req_valid = 1'b0;
    check("or_exec_sel", 32'(alu_select), 32'd7);
    check("or_exec_a",   32'(alu_a), 32'd4);
    check("or_exec_b",   32'(alu_b), 32'd3);
    check("or_busy",     32'(busy), 32'd1);
    @(negedge clk);
    check("or_wb_en",   32'(wb_en), 32'd1);
    check("or_wb_addr", 32'(wb_addr), 32'd7);
    check("or_wb_data", 32'(wb_data), 32'd7);
    check("or_done",    32'(done), 32'd1);
    @(negedge clk);

    run_op("mul",  3'd2, 16'd5, 16'hfffb, 4'd2, 4'd0, 2, 4'd2, 4'd15, 16'hffe7, 16'hffff, 1'b0);
    run_op("div",  3'd3, 16'd5, 16'd2,    4'd4, 4'd0, 2, 4'd4, 4'd15, 16'd2,    16'd1,    1'b0);
    run_op("swap", 3'd5, 16'd100, 16'd2,  4'd1, 4'd6, 2, 4'd1, 4'd6,  16'd2,    16'd100,  1'b0);
    run_op("swap_coll", 3'd5, 16'h1234, 16'habcd, 4'd9, 4'd9, 2, 4'd9, 4'd9, 16'habcd, 16'h1234, 1'b0);
    run_op("mul_coll",  3'd2, 16'd300, 16'd300, 4'd15, 4'd0, 2, 4'd15, 4'd15, 16'h5f90, 16'h0001, 1'b0);
`ifdef ALU_ISSUE_DIVZERO_CHK_EN
    run_op("divz", 3'd3, 16'd9, 16'd0, 4'd5, 4'd0, 0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
`else
    run_op("divz", 3'd3, 16'd9, 16'd0, 4'd5, 4'd0, 2, 4'd5, 4'd15, 16'hffff, 16'd9, 1'b0);
`endif

    // reset lands during the EXEC cycle of a mul
    req_valid = 1'b1; req_op = 3'd2; req_a = 16'd7; req_b = 16'd3; req_rd1 = 4'd5;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mrst_wb_en", 32'(wb_en), 32'd0);
    check("mrst_busy",  32'(busy), 32'd0);
    check("mrst_sel",   32'(alu_select), 32'd0);
    check("mrst_alu_a", 32'(alu_a), 32'd0);
    check("mrst_waddr", 32'(wb_addr), 32'd0);
    check("mrst_wdata", 32'(wb_data), 32'd0);
    check("mrst_done",  32'(done), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready_after", 32'(req_ready), 32'd1);
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_en) wcnt++;
      @(negedge clk);
    end
    check("mrst_no_wb", 32'(wcnt), 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (rop == 3'd3 && $urandom_range(0, 3) == 0) rb = 16'h0;
      r1  = 4'($urandom);
      r2  = 4'($urandom);
      ref_op(rop, ra, rb, r1, r2, n, a0, a1, d0, d1, er);
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, r1, r2, n, a0, a1, d0, d1, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequences one operation at a time through the shared 16-bit ALU (ops: add, sub, mul, div, move, swap, and, or).
- Accepts operation requests over a valid/ready handshake and latches the operands.
- Drives the ALU, captures its three result outputs (op1data, op2data, r15) and serialises the required register-file writebacks over a single write port.
- Sits between instruction decode and the register file.

Parameters:
DATA_W, 16, operand/result width
REG_AW, 4, register address width
R15_ADDR, 15, register index that receives the ALU r15 output (mul high half / div remainder)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_op  input  3  0 add, 1 sub, 2 mul, 3 div, 4 move, 5 swap, 6 and, 7 or
req_a  input  DATA_W  operand A (signed)
req_b  input  DATA_W  operand B (signed)
req_rd1  input  REG_AW  destination for op1 result
req_rd2  input  REG_AW  destination for op2 result (swap only)
alu_a  output  DATA_W  ALU a input
alu_b  output  DATA_W  ALU b input
alu_select  output  3  ALU aluSelect
alu_op1data  input  DATA_W  ALU op1data
alu_op2data  input  DATA_W  ALU op2data
alu_r15  input  DATA_W  ALU r15
wb_en  output  1  register write strobe
wb_addr  output  REG_AW  write address
wb_data  output  DATA_W  write data
done  output  1  one-cycle pulse on final writeback of an op
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle divide-by-zero pulse (see Optional Feature)

Behaviour:
- Clock is clk. Reset is rst: synchronous and active-high. Reset is sampled on the rising edge only.
- Reset values: state = IDLE; alu_a, alu_b, alu_select, wb_addr, wb_data = 0; wb_en, done, busy, err = 0. req_ready = 0 while rst is high.
- States: IDLE, EXEC, WB1, WB2.
- IDLE: req_ready = 1. On an edge with req_valid & req_ready, latch op, a, b, rd1 and rd2, then go to EXEC.
- EXEC (1 cycle):
  - alu_a/alu_b/alu_select are driven from the latched registers; they are held from the EXEC cycle until the next accept.
  - At the end of the cycle, capture alu_op1data, alu_op2data and alu_r15 into result registers.
  - Go to WB1.
- WB1:
  - wb_en = 1, wb_addr = rd1, wb_data = captured op1.
  - For add, sub, move, and, or: done = 1 this cycle; next state IDLE.
  - For mul, div, swap: next state WB2.
- WB2:
  - swap: wb_addr = rd2, wb_data = captured op2.
  - mul/div: wb_addr = R15_ADDR, wb_data = captured r15.
  - wb_en = 1 and done = 1; next state IDLE.
- Latency, with accept on edge k:
  - EXEC is cycle k+1.
  - First write is in cycle k+2.
  - Two-write ops finish in cycle k+3.
  - req_ready returns high the cycle after done.
  - Maximum throughput is one op per 3 or 4 cycles.
- wb_en is 0 in IDLE and EXEC. wb_addr/wb_data hold their last value when wb_en = 0.
- Address collision (swap with rd1 == rd2, or mul/div with rd1 == R15_ADDR): both writes are issued in order, so the WB2 value is what remains in the register file.
- req_valid asserted while busy: ignored, with no latching. The requester must hold its request until it sees ready.
- Reset mid-operation: abort on the edge, issue no further wb_en, and enter IDLE. Writes already issued are not undone.
- The controller performs no arithmetic. Width and sign semantics are the ALU's; data passes through unmodified.

Optional Feature:
- Macro: ALU_ISSUE_DIVZERO_CHK_EN.
- Defined:
  - When a div request is latched with b == 0, EXEC is replaced by a single-cycle abort.
  - No wb_en is issued; err = 1 and done = 1 in that cycle; the next state is IDLE.
  - The ALU is still driven but its outputs are discarded.
- Not defined:
  - err is tied to 0.
  - div with b == 0 writes back whatever the ALU produces, through the normal WB1/WB2 sequence.

Test Plan:
- add: a=15, b=10, rd1=3 accepted at edge k -> cycle k+2: wb_en=1, wb_addr=3, wb_data=25, done=1; req_ready=1 in cycle k+3.
- mul: a=5, b=-5, rd1=2 -> WB1 writes r2 = 0xFFE7; WB2 writes r15 = 0xFFFF; done only in WB2; exactly 2 wb_en cycles.
- div and swap:
  - div: a=5, b=2, rd1=4 -> r4 = 2, then r15 = 1.
  - swap: a=100, b=2, rd1=1, rd2=6 -> r1 = 2, then r6 = 100.
- Back-to-back requests: req_valid held high with op=or, a=4, b=3, rd1=7 while busy with the prior add -> no accept until after done; then wb r7 = 7; alu_select = 7 during EXEC.
- Reset mid-operation: rst asserted during the EXEC cycle of mul -> zero wb_en cycles afterwards; outputs at reset values; req_ready=1 the cycle after rst deasserts.
- Divide by zero: div a=9, b=0 with ALU_ISSUE_DIVZERO_CHK_EN defined -> err=1 and done=1 in one cycle, no wb_en. Without the macro -> two writebacks occur and err stays 0.
